rsbus_frame_aligner: RTL
========================

// Module: rsbus_frame_aligner
// PURPOSE
//  Ring-bus frame master: runs the local frame timebase (one header slot every FRAME_LEN cycles).
//  Measures the phase of frames returning around the ring and re-times them onto that timebase
//  through a variable-tap delay line. Adds lock tracking, loss-of-alignment detection,
//  automatic/commanded re-acquire and a frame counter. Sits at the ring-closing node, ahead of the ring output.
// PARAMETERS
//  FRAME_LEN  11   slots per frame, >=2
//  DEPTH      16   delay-line taps, >=FRAME_LEN
//  CTRL_W     12   control word width ($bits(rbus_ctrl_t))
//  BUS_W      72   data word width ($bits(rbus_word_t))
//  MARK_BIT   39   bus bit carrying the frame-parity marker in header slot
//  MAX_MISS   3    consecutive alignment misses before re-acquire, >=1
//  FCNT_W     16   frame counter width
// PORTS
//  clk          in   1                   clock
//  rst          in   1                   asynchronous reset, active high
//  i_sof        in   1                   header slot of returning frame
//  i_ctrl       in   CTRL_W              returning control word
//  i_bus        in   BUS_W               returning data word
//  i_resync     in   1                   1-cycle command: drop lock, re-acquire
//  o_sof        out  1                   local header slot strobe
//  o_ctrl       out  CTRL_W              re-timed control word
//  o_bus        out  BUS_W               re-timed data word
//  o_locked     out  1                   state==LOCKED
//  o_err        out  1                   1-cycle pulse on loss of alignment
//  o_offset     out  $clog2(DEPTH)       active tap
//  o_frame_cnt  out  FCNT_W              headers emitted since reset, wraps
// BEHAVIOUR
//  Reset: all outputs 0, phase ph=0, state ACQUIRE, offset 0, miss 0, idle gate on.
//  Delay line is not reset.
//  Timebase: ph counts 0..FRAME_LEN-1 and wraps, free-running in every state.
//  o_sof is registered: high the cycle after ph==0. o_frame_cnt increments with each o_sof.
//  Datapath: tap k at cycle t holds input of cycle t-1-k. Output is tap[offset], registered.
//  Total latency i_sof->o_sof = offset+2.
//  Idle gate: while the gate is on, o_ctrl=0 and o_bus=0, except o_bus[MARK_BIT].
//  Header slot: o_bus[MARK_BIT] = ~o_frame_cnt[0] (value before increment). It overrides data in every state.
//  ACQUIRE: the first i_sof seen at phase p does the following:
//   - loads offset = (FRAME_LEN-1-p) mod FRAME_LEN
//   - loads p_lock = p
//   - clears miss
//   - moves to LOCKED on the next edge
//   - leaves the gate on
//  LOCKED: the gate turns off on the first read cycle with ph==0, so output frames are never torn.
//   Miss event: i_sof at ph!=p_lock, or no i_sof at ph==p_lock. Miss events increment miss (saturating).
//   i_sof at ph==p_lock clears miss.
//   When miss reaches MAX_MISS:
//    - o_err pulses
//    - state goes to ACQUIRE and the gate turns on
//    - offset holds its value until the next capture
//  i_resync, any state: go to ACQUIRE, gate on, miss=0, no o_err.
//   An i_sof in the same cycle is ignored; capture uses a later i_sof.
//  Two i_sof in one frame while in LOCKED: each off-phase pulse counts as one miss.
//  Reset mid-frame: immediate return to reset state. The first o_sof comes 2 cycles after rst release.
// STRUCTURE
//  rbus_pkg: rbus_ctrl_t, rbus_word_t, and the aligner state enum (ACQUIRE, LOCKED).
//  Sub-module rsbus_frame_delay_line: DEPTH x (CTRL_W+BUS_W) variable-tap line, no reset.
//   `NO_SHIFT_REGS selects the distributed-RAM ring-pointer version; otherwise a shift register is used.
//  The top holds the timebase, FSM, miss counter, idle gate and output register.
// TESTING
//  1 Reset release with no i_sof: o_sof at cycles 2,13,24,... Marker alternates 1,0,1.
//    o_ctrl/o_bus data are 0 and o_locked=0.
//  2 Loop output to input with ring delay 5, word = slot index:
//    - capture at p=6, offset=4, o_locked next cycle
//    - the first ungated frame reproduces input exactly, o_sof aligned, latency 6
//  3 Offset extremes: i_sof at p=FRAME_LEN-1 -> offset 0. i_sof at p=0 -> offset FRAME_LEN-1.
//    Data is intact in both cases.
//  4 After lock, shift i_sof by one slot for 3 frames:
//    - miss counts 1,2,3
//    - o_err pulses once, o_locked=0, gate on
//    - the next i_sof re-captures at the new phase
//  5 i_resync coincident with i_sof while LOCKED: that i_sof is ignored.
//    Lock is re-acquired on the following frame's i_sof. No o_err.
//  6 Assert rst mid-frame while LOCKED: all outputs 0 during reset, state ACQUIRE, o_frame_cnt=0.

Source files
------------

// File: rtl/rsbus_frame_aligner_pkg.sv
// Ring-bus word types and the frame aligner state encoding, shared by the aligner slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the ring is a fixed-rate slotted bus with no flow control.
package rbus_pkg;

    typedef struct packed {
        logic [3:0] kind;
        logic [7:0] dest;
    } rbus_ctrl_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [63:0] payload;
    } rbus_word_t;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } aln_state_t;

    localparam int RBUS_CTRL_W = $bits(rbus_ctrl_t);
    localparam int RBUS_BUS_W  = $bits(rbus_word_t);

endpackage

// File: rtl/rsbus_frame_delay_line.sv
// Variable-tap delay line: tap k holds the input word from k+1 cycles ago; dout = tap[sel].
// Latency: 1 cycle to tap 0, sel+1 cycles to dout (dout is combinational from the taps).
// Backpressure: none; shifts every cycle. Storage is not reset.
// Ports: clk, rst (ring-pointer build only), din (word in), sel (tap select), dout (selected tap).
module rsbus_frame_delay_line #(
    parameter int DEPTH = 16,
    parameter int W     = 84,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic             clk,
`ifdef NO_SHIFT_REGS
    input  logic             rst,
`endif
    input  logic [W-1:0]     din,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     dout
);

`ifdef NO_SHIFT_REGS
    logic [W-1:0]     mem [DEPTH];
    logic [SEL_W-1:0] wptr;
    logic [SEL_W:0]   ridx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              wptr <= '0;
        else if (wptr == SEL_W'(DEPTH - 1))   wptr <= '0;
        else                                  wptr <= wptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        mem[wptr] <= din;
    end

    // Newest word sits at wptr-1, so tap k lives at (wptr-1-k) mod DEPTH.
    always_comb begin
        ridx = {1'b0, wptr} + (SEL_W + 1)'(DEPTH - 1) - {1'b0, sel};
        if (ridx >= (SEL_W + 1)'(DEPTH)) ridx = ridx - (SEL_W + 1)'(DEPTH);
    end

    assign dout = mem[ridx[SEL_W-1:0]];
`else
    logic [W-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        taps[0] <= din;
        for (int k = 1; k < DEPTH; k++) taps[k] <= taps[k-1];
    end

    assign dout = taps[sel];
`endif

endmodule

// File: rtl/rsbus_frame_aligner.sv
// Ring-closing frame master: local frame timebase plus re-timing of returning frames onto it.
// Latency: i_sof -> o_sof is offset+2 cycles; outputs are registered.
// Backpressure: none; the ring runs at a fixed slot rate, misaligned input is gated, not stalled.
// Ports: clk/rst; returning frame i_sof/i_ctrl/i_bus; i_resync command; re-timed frame
//        o_sof/o_ctrl/o_bus; status o_locked, o_err (loss-of-alignment pulse), o_offset, o_frame_cnt.
module rsbus_frame_aligner
    import rbus_pkg::*;
#(
    parameter int FRAME_LEN = 11,
    parameter int DEPTH     = 16,
    parameter int CTRL_W    = RBUS_CTRL_W,
    parameter int BUS_W     = RBUS_BUS_W,
    parameter int MARK_BIT  = 39,
    parameter int MAX_MISS  = 3,
    parameter int FCNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_sof,
    input  logic [CTRL_W-1:0]        i_ctrl,
    input  logic [BUS_W-1:0]         i_bus,
    input  logic                     i_resync,
    output logic                     o_sof,
    output logic [CTRL_W-1:0]        o_ctrl,
    output logic [BUS_W-1:0]         o_bus,
    output logic                     o_locked,
    output logic                     o_err,
    output logic [$clog2(DEPTH)-1:0] o_offset,
    output logic [FCNT_W-1:0]        o_frame_cnt
);

    localparam int PH_W   = $clog2(FRAME_LEN);
    localparam int OFF_W  = $clog2(DEPTH);
    localparam int MISS_W = $clog2(MAX_MISS + 1);
    localparam int DW     = CTRL_W + BUS_W;

    logic [PH_W-1:0]   ph, p_lock, p_lock_nxt;
    logic [OFF_W-1:0]  offset, offset_nxt;
    logic [MISS_W-1:0] miss, miss_nxt, miss_inc;
    logic              gate, gate_nxt, err_nxt;
    logic              hdr, on_phase, read_open;
    aln_state_t        state, state_nxt;
    logic [DW-1:0]     tap;
    logic [CTRL_W-1:0] ctrl_d;
    logic [BUS_W-1:0]  bus_d;

    rsbus_frame_delay_line #(
        .DEPTH (DEPTH),
        .W     (DW),
        .SEL_W (OFF_W)
    ) u_dly (
        .clk  (clk),
`ifdef NO_SHIFT_REGS
        .rst  (rst),
`endif
        .din  ({i_ctrl, i_bus}),
        .sel  (offset),
        .dout (tap)
    );

    // Free-running local timebase; header slot is read when ph==0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               ph <= '0;
        else if (ph == PH_W'(FRAME_LEN - 1))   ph <= '0;
        else                                   ph <= ph + 1'b1;
    end

    assign hdr      = (ph == '0);
    assign on_phase = (ph == p_lock);
    assign miss_inc = (miss == MISS_W'(MAX_MISS)) ? miss : miss + 1'b1;

    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        p_lock_nxt = p_lock;
        miss_nxt   = miss;
        gate_nxt   = gate;
        err_nxt    = 1'b0;
        if (i_resync) begin
            // A same-cycle i_sof is deliberately ignored here.
            state_nxt = ACQUIRE;
            gate_nxt  = 1'b1;
            miss_nxt  = '0;
        end else begin
            case (state)
                ACQUIRE: begin
                    if (i_sof) begin
                        // Chosen so the captured header leaves on the cycle after ph==0.
                        offset_nxt = OFF_W'(FRAME_LEN - 1 - int'(ph));
                        p_lock_nxt = ph;
                        miss_nxt   = '0;
                        state_nxt  = LOCKED;
                    end
                end
                LOCKED: begin
                    // Opening only at a header read keeps output frames whole.
                    if (hdr) gate_nxt = 1'b0;
                    if (i_sof && on_phase) begin
                        miss_nxt = '0;
                    end else if (i_sof || on_phase) begin
                        miss_nxt = miss_inc;
                        if (miss_inc == MISS_W'(MAX_MISS)) begin
                            err_nxt   = 1'b1;
                            state_nxt = ACQUIRE;
                            gate_nxt  = 1'b1;
                        end
                    end
                end
                default: state_nxt = ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ACQUIRE;
            offset <= '0;
            p_lock <= '0;
            miss   <= '0;
            gate   <= 1'b1;
        end else begin
            state  <= state_nxt;
            offset <= offset_nxt;
            p_lock <= p_lock_nxt;
            miss   <= miss_nxt;
            gate   <= gate_nxt;
        end
    end

    // The header read in LOCKED is the one that opens the gate, so it is already ungated.
    assign read_open = ~gate | ((state == LOCKED) & hdr);

    always_comb begin
        ctrl_d = '0;
        bus_d  = '0;
        if (read_open) {ctrl_d, bus_d} = tap;
        if (hdr) bus_d[MARK_BIT] = ~o_frame_cnt[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sof       <= 1'b0;
            o_ctrl      <= '0;
            o_bus       <= '0;
            o_err       <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_sof  <= hdr;
            o_ctrl <= ctrl_d;
            o_bus  <= bus_d;
            o_err  <= err_nxt;
            if (hdr) o_frame_cnt <= o_frame_cnt + 1'b1;
        end
    end

    assign o_locked = (state == LOCKED);
    assign o_offset = offset;

endmodule
